canv_arb: RTL and testbench

Two-requester write arbiter for the single canvas framebuffer write port in the `clk_sys` domain. It shares the port between the CPU (requester 0) and the Earthrise drawing engine (requester 1). Grants are round-robin, and a grant is held for a burst. A burst ends on a last-beat flag, a beat limit or an idle-gap timeout. A `pause` input lets the frame-swap logic hold off new grants without cutting a burst short.

---
 rtl/canv_pkg.sv | 33 +++
 rtl/arb_rr2.sv | 34 +++
 rtl/canv_arb.sv | 201 ++++++++++++++++++++
 tb/tb_canv_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canv_pkg.sv
// Shared definitions for the canvas framebuffer write arbiter: state
// encodings, requester indices and the default canvas geometry.
`timescale 1ns/1ps
package canv_pkg;

    // Canvas geometry: 336x192 words of CANV_BPP-bit pixels.
    localparam int CANV_ADDRW = 16;
    localparam int CANV_DATAW = 4;

    // Requester indices into the req_* vectors.
    localparam int REQ_CPU = 0;
    localparam int REQ_ER  = 1;

    // Arbiter states. The OWN encodings double as the one-hot grant value.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        REL  = 2'd3
    } canv_state_e;

    // One-hot owner of the write port for a given state, 0 when nobody owns it.
    function automatic logic [1:0] owner_onehot(input canv_state_e st);
        logic [1:0] oh;
        case (st)
            OWN0:    oh = 2'b01;
            OWN1:    oh = 2'b10;
            default: oh = 2'b00;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick. Purely combinational: given the pending
// requests, the last owner and the pause flag, it names the requester that
// should own the port next (one-hot), or nobody.
`timescale 1ns/1ps
module arb_rr2
    import canv_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       rr_last,
    input  logic       pause,
    output logic [1:0] pick
);

    // Pause wins outright; a tie goes to whoever did not own the port last.
    always_comb begin
        pick = 2'b00;
        if (pause) begin
            pick = 2'b00;
        end else if (req_valid[REQ_CPU] && req_valid[REQ_ER]) begin
            if (rr_last == 1'(REQ_ER)) begin
                pick[REQ_CPU] = 1'b1;
            end else begin
                pick[REQ_ER] = 1'b1;
            end
        end else if (req_valid[REQ_CPU]) begin
            pick[REQ_CPU] = 1'b1;
        end else if (req_valid[REQ_ER]) begin
            pick[REQ_ER] = 1'b1;
        end else begin
            pick = 2'b00;
        end
    end

endmodule

// File: rtl/canv_arb.sv
// Canvas framebuffer write-port arbiter. The CPU and the Earthrise engine
// share one write port; ownership is granted round-robin and held for a
// burst that ends on req_last, after BURST_MAX beats, or after GAP_MAX idle
// owned cycles. Every handover passes through a one-cycle REL bubble.
`timescale 1ns/1ps
module canv_arb
    import canv_pkg::*;
#(
    parameter int ADDRW     = CANV_ADDRW,
    parameter int DATAW     = CANV_DATAW,
    parameter int BURST_MAX = 16,
    parameter int GAP_MAX   = 4
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_last,
    input  logic [ADDRW-1:0] req_addr0,
    input  logic [ADDRW-1:0] req_addr1,
    input  logic [DATAW-1:0] req_data0,
    input  logic [DATAW-1:0] req_data1,
    input  logic             pause,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_data
);

    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam int GCW = $clog2(GAP_MAX + 1);
    // Counter values at which the next qualifying cycle ends the burst.
    localparam logic [BCW-1:0] BEAT_FINAL = BCW'(BURST_MAX - 1);
    localparam logic [GCW-1:0] GAP_FINAL  = GCW'(GAP_MAX - 1);

    canv_state_e      state_r;
    canv_state_e      next_state_s;
    logic [1:0]       grant_r;
    logic             busy_r;
    logic             mem_we_r;
    logic [ADDRW-1:0] mem_addr_r;
    logic [DATAW-1:0] mem_data_r;
    logic [BCW-1:0]   beat_cnt_r;
    logic [GCW-1:0]   gap_cnt_r;
    logic             rr_last_r;

    logic [1:0]       pick_s;
    logic             owning_s;
    logic             own_idx_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic [ADDRW-1:0] sel_addr_s;
    logic [DATAW-1:0] sel_data_s;
    logic             acc_s;
    logic             beat_done_s;
    logic             gap_done_s;
    logic             rel_s;

    arb_rr2 u_pick (
        .req_valid (req_valid),
        .rr_last   (rr_last_r),
        .pause     (pause),
        .pick      (pick_s)
    );

    // Which requester, if any, currently owns the port.
    always_comb begin
        owning_s  = 1'b0;
        own_idx_s = 1'(REQ_CPU);
        case (state_r)
            OWN0: begin
                owning_s  = 1'b1;
                own_idx_s = 1'(REQ_CPU);
            end
            OWN1: begin
                owning_s  = 1'b1;
                own_idx_s = 1'(REQ_ER);
            end
            default: begin
                owning_s  = 1'b0;
                own_idx_s = 1'(REQ_CPU);
            end
        endcase
    end

    // Route the owning requester's beat onto a single set of wires.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_addr_s  = req_addr0;
        sel_data_s  = req_data0;
        if (own_idx_s == 1'(REQ_ER)) begin
            sel_valid_s = req_valid[REQ_ER];
            sel_last_s  = req_last[REQ_ER];
            sel_addr_s  = req_addr1;
            sel_data_s  = req_data1;
        end else begin
            sel_valid_s = req_valid[REQ_CPU];
            sel_last_s  = req_last[REQ_CPU];
            sel_addr_s  = req_addr0;
            sel_data_s  = req_data0;
        end
    end

    // Beat acceptance and the three ways a burst can end.
    always_comb begin
        acc_s       = owning_s & sel_valid_s;
        beat_done_s = acc_s & (sel_last_s | (beat_cnt_r == BEAT_FINAL));
        gap_done_s  = owning_s & ~sel_valid_s & (gap_cnt_r == GAP_FINAL);
        rel_s       = beat_done_s | gap_done_s;
    end

    // Next-state logic; pause only matters while choosing a new owner in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_s[REQ_CPU]) begin
                    next_state_s = OWN0;
                end else if (pick_s[REQ_ER]) begin
                    next_state_s = OWN1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (rel_s) begin
                    next_state_s = REL;
                end else begin
                    next_state_s = state_r;
                end
            end
            REL:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs: grant follows the state, writes land one cycle after acceptance.
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            grant_r    <= 2'b00;
            busy_r     <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
        end else begin
            grant_r  <= owner_onehot(next_state_s);
            busy_r   <= (next_state_s != IDLE) | acc_s;
            mem_we_r <= acc_s;
            if (acc_s) begin
                mem_addr_r <= sel_addr_s;
                mem_data_r <= sel_data_s;
            end else begin
                mem_addr_r <= mem_addr_r;
                mem_data_r <= mem_data_r;
            end
        end
    end

    // Beat and idle-gap counters, plus the round-robin memory of the last owner.
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            beat_cnt_r <= '0;
            gap_cnt_r  <= '0;
            rr_last_r  <= 1'b1;
        end else if (rel_s) begin
            beat_cnt_r <= '0;
            gap_cnt_r  <= '0;
            rr_last_r  <= own_idx_s;
        end else if (owning_s) begin
            if (acc_s) begin
                beat_cnt_r <= beat_cnt_r + BCW'(1);
                gap_cnt_r  <= '0;
            end else begin
                gap_cnt_r  <= gap_cnt_r + GCW'(1);
            end
        end else begin
            beat_cnt_r <= '0;
            gap_cnt_r  <= '0;
        end
    end

    // The ready bits are the grant itself: only the owner may push beats.
    assign req_ready = grant_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_data  = mem_data_r;

endmodule

// File: tb/tb_canv_arb.sv
// Self-checking bench for canv_arb: a per-cycle vector table for a single
// burst, requester models feeding a write scoreboard for the multi-burst
// cases, and a hand-driven reset-during-burst sequence.
`timescale 1ns/1ps
module tb_canv_arb;
    import canv_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  data;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct {
        logic        rst_n;
        logic [1:0]  valid;
        logic [1:0]  last;
        logic [15:0] addr0;
        logic [3:0]  data0;
        logic        pause;
        logic [1:0]  e_grant;
        logic [1:0]  e_ready;
        logic        e_we;
        logic        e_busy;
        logic [15:0] e_addr;
        logic [3:0]  e_data;
    } vec_t;

    logic        clk_sys;
    logic        rst_sys_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_last;
    logic [15:0] req_addr0;
    logic [15:0] req_addr1;
    logic [3:0]  req_data0;
    logic [3:0]  req_data1;
    logic        pause;
    logic [1:0]  grant;
    logic        busy;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [3:0]  mem_data;

    int checks;
    int errors;

    beat_t pend [2][$];
    beat_t expq [2][$];
    int    gapleft [2];
    bit    loaded [2];
    bit    pushed [2];
    bit    acc [2];
    int    wr_cnt [2];
    int    cyc;
    int    p_on;
    int    p_off;
    logic [1:0] glog [256];
    logic       blog [256];

    vec_t       tv [9];
    logic [1:0] exp_t2 [11];
    logic [1:0] exp_t4 [13];
    logic [1:0] exp_t5 [13];

    canv_arb #(
        .ADDRW     (16),
        .DATAW     (4),
        .BURST_MAX (16),
        .GAP_MAX   (4)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_last  (req_last),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .pause     (pause),
        .grant     (grant),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_beat(input int i, input logic [15:0] a, input logic [3:0] d,
                            input logic l, input int g);
        beat_t b;
        b.addr = a;
        b.data = d;
        b.last = l;
        b.gap  = g;
        pend[i].push_back(b);
    endtask

    // Requester models: present the front beat (after its pre-gap), retire it once accepted.
    task automatic drive_reqs();
        beat_t b;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                if (pend[i].size() > 0) b = pend[i].pop_front();
                loaded[i] = 1'b0;
                acc[i]    = 1'b0;
            end
            if (pend[i].size() > 0) begin
                if (!loaded[i]) begin
                    gapleft[i] = pend[i][0].gap;
                    loaded[i]  = 1'b1;
                    pushed[i]  = 1'b0;
                end
                if (gapleft[i] > 0) begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    gapleft[i]--;
                end else begin
                    b = pend[i][0];
                    req_valid[i] = 1'b1;
                    req_last[i]  = b.last;
                    if (i == 0) begin
                        req_addr0 = b.addr;
                        req_data0 = b.data;
                    end else begin
                        req_addr1 = b.addr;
                        req_data1 = b.data;
                    end
                    if (!pushed[i]) begin
                        expq[i].push_back(b);
                        pushed[i] = 1'b1;
                    end
                end
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        pause = (cyc >= p_on) && (cyc < p_off);
    endtask

    task automatic sb_write();
        beat_t b;
        int s;
        s = mem_addr[15] ? 1 : 0;
        if (expq[s].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got write addr 0x%0h data 0x%0h, expected no write",
                     mem_addr, mem_data);
        end else begin
            b = expq[s].pop_front();
            check($sformatf("sb_write_r%0d", s), 32'({mem_addr, mem_data}), 32'({b.addr, b.data}));
            wr_cnt[s]++;
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        if (cyc < 256) begin
            glog[cyc] = grant;
            blog[cyc] = busy;
        end
        if (mem_we) sb_write();
        for (int i = 0; i < 2; i++) acc[i] = req_valid[i] & req_ready[i];
        @(posedge clk_sys);
        #1;
        cyc++;
        drive_reqs();
    endtask

    task automatic do_reset();
        rst_sys_n = 1'b0;
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_addr0 = 16'h0000;
        req_addr1 = 16'h0000;
        req_data0 = 4'h0;
        req_data1 = 4'h0;
        pause     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i].delete();
            expq[i].delete();
            gapleft[i] = 0;
            loaded[i]  = 1'b0;
            pushed[i]  = 1'b0;
            acc[i]     = 1'b0;
            wr_cnt[i]  = 0;
        end
        p_on  = 100000;
        p_off = 100000;
        for (int k = 0; k < 256; k++) begin
            glog[k] = 2'bxx;
            blog[k] = 1'bx;
        end
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic start();
        rst_sys_n = 1'b1;
        cyc = 0;
        drive_reqs();
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (((pend[0].size() + pend[1].size() + expq[0].size() + expq[1].size()) != 0 || busy)
               && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, "_drained"},
              32'(pend[0].size() + pend[1].size() + expq[0].size() + expq[1].size()), 32'd0);
    endtask

    task automatic check_g(input string name, input int c, input logic [1:0] e);
        check($sformatf("%s_grant_c%0d", name, c), 32'(glog[c]), 32'(e));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ---- Test 1: single CPU burst of three beats, then pause held in IDLE ----
        //          rst   valid  last   addr0     d0    pause  grant  ready  we    busy  addr      data
        tv[0] = '{1'b1, 2'b01, 2'b00, 16'h0010, 4'h1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 4'h0};
        tv[1] = '{1'b1, 2'b01, 2'b00, 16'h0010, 4'h1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000, 4'h0};
        tv[2] = '{1'b1, 2'b01, 2'b00, 16'h0011, 4'h2, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 16'h0010, 4'h1};
        tv[3] = '{1'b1, 2'b01, 2'b01, 16'h0012, 4'h3, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 16'h0011, 4'h2};
        tv[4] = '{1'b1, 2'b00, 2'b00, 16'h0012, 4'h3, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 16'h0012, 4'h3};
        tv[5] = '{1'b1, 2'b00, 2'b00, 16'h0012, 4'h3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0012, 4'h3};
        tv[6] = '{1'b1, 2'b01, 2'b00, 16'h0020, 4'h5, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0012, 4'h3};
        tv[7] = '{1'b1, 2'b01, 2'b00, 16'h0020, 4'h5, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0012, 4'h3};
        tv[8] = '{1'b1, 2'b01, 2'b00, 16'h0020, 4'h5, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0012, 4'h3};
        do_reset();
        for (int r = 0; r < 9; r++) begin
            rst_sys_n = tv[r].rst_n;
            req_valid = tv[r].valid;
            req_last  = tv[r].last;
            req_addr0 = tv[r].addr0;
            req_data0 = tv[r].data0;
            pause     = tv[r].pause;
            @(negedge clk_sys);
            check($sformatf("t1_ctl_r%0d", r), 32'({grant, req_ready, mem_we, busy}),
                  32'({tv[r].e_grant, tv[r].e_ready, tv[r].e_we, tv[r].e_busy}));
            check($sformatf("t1_mem_r%0d", r), 32'({mem_addr, mem_data}),
                  32'({tv[r].e_addr, tv[r].e_data}));
            @(posedge clk_sys);
            #1;
        end

        // ---- Test 2: tie after reset goes to CPU, then strict alternation ----
        exp_t2 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
        do_reset();
        add_beat(0, 16'h0100, 4'h1, 1'b0, 0);
        add_beat(0, 16'h0101, 4'h2, 1'b0, 0);
        add_beat(0, 16'h0102, 4'h3, 1'b1, 0);
        add_beat(0, 16'h0103, 4'h4, 1'b1, 0);
        add_beat(1, 16'h8000, 4'hA, 1'b0, 0);
        add_beat(1, 16'h8001, 4'hB, 1'b1, 0);
        add_beat(1, 16'h8002, 4'hC, 1'b1, 0);
        start();
        drain("t2", 200);
        for (int c = 0; c < 11; c++) check_g("t2", c, exp_t2[c]);
        check("t2_wr_cpu", 32'(wr_cnt[0]), 32'd4);
        check("t2_wr_er",  32'(wr_cnt[1]), 32'd3);

        // ---- Test 3: 40-beat Earthrise stream split at BURST_MAX, CPU slotted in ----
        do_reset();
        for (int k = 0; k < 40; k++) add_beat(1, 16'(32'h8000 + k), 4'(k), 1'b0, 0);
        add_beat(0, 16'h0040, 4'h9, 1'b0, 3);
        add_beat(0, 16'h0041, 4'hA, 1'b1, 0);
        start();
        drain("t3", 300);
        check_g("t3", 16, 2'b10);
        check_g("t3", 17, 2'b00);
        check_g("t3", 18, 2'b00);
        check_g("t3", 19, 2'b01);
        check_g("t3", 23, 2'b10);
        check_g("t3", 39, 2'b00);
        check_g("t3", 41, 2'b10);
        check("t3_wr_er",  32'(wr_cnt[1]), 32'd40);
        check("t3_wr_cpu", 32'(wr_cnt[0]), 32'd2);

        // ---- Test 4: CPU goes quiet for GAP_MAX cycles, Earthrise takes over ----
        exp_t4 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                   2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        do_reset();
        add_beat(0, 16'h0050, 4'h1, 1'b0, 0);
        add_beat(0, 16'h0051, 4'h2, 1'b0, 0);
        add_beat(0, 16'h0052, 4'h3, 1'b1, 4);
        add_beat(1, 16'h8200, 4'h7, 1'b1, 1);
        start();
        drain("t4", 200);
        for (int c = 0; c < 13; c++) check_g("t4", c, exp_t4[c]);
        check("t4_wr_cpu", 32'(wr_cnt[0]), 32'd3);

        // ---- Test 5: pause during a 5-beat burst, grant resumes after pause falls ----
        exp_t5 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        do_reset();
        for (int k = 0; k < 5; k++) add_beat(0, 16'(32'h0060 + k), 4'(k + 1), (k == 4), 0);
        add_beat(1, 16'h8300, 4'hE, 1'b1, 1);
        p_on  = 2;
        p_off = 11;
        start();
        drain("t5", 200);
        for (int c = 0; c < 13; c++) check_g("t5", c, exp_t5[c]);
        check("t5_busy_c6", 32'(blog[6]), 32'd1);
        check("t5_busy_c7", 32'(blog[7]), 32'd0);
        check("t5_wr_cpu", 32'(wr_cnt[0]), 32'd5);

        // ---- Test 6: reset during beat 3 of an Earthrise burst ----
        do_reset();
        rst_sys_n = 1'b1;
        req_valid = 2'b11;
        req_last  = 2'b01;
        req_addr0 = 16'h0030;
        req_data0 = 4'h7;
        req_addr1 = 16'h8100;
        req_data1 = 4'h1;
        @(posedge clk_sys); #1;      // cycle 1: CPU owns, beat accepted at next edge
        @(posedge clk_sys); #1;      // cycle 2: REL
        req_valid = 2'b10;
        @(posedge clk_sys); #1;      // cycle 3: IDLE, only Earthrise pending
        @(posedge clk_sys); #1;      // cycle 4: Earthrise owns
        @(negedge clk_sys);
        check("t6_er_grant", 32'(grant), 32'(2'b10));
        @(posedge clk_sys); #1;      // cycle 5: beat 2
        req_addr1 = 16'h8101;
        req_data1 = 4'h2;
        @(posedge clk_sys); #1;      // cycle 6: beat 3 presented with reset asserted
        req_addr1 = 16'h8102;
        req_data1 = 4'h3;
        rst_sys_n = 1'b0;
        @(negedge clk_sys);
        check("t6_pre_rst_we",  32'({mem_we, mem_addr, mem_data}), 32'({1'b1, 16'h8101, 4'h2}));
        @(posedge clk_sys); #1;      // cycle 7: reset taken
        rst_sys_n = 1'b1;
        req_valid = 2'b11;
        req_addr0 = 16'h0031;
        req_data0 = 4'h8;
        @(negedge clk_sys);
        check("t6_rst_grant", 32'(grant), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_we",    32'(mem_we), 32'd0);
        check("t6_rst_busy",  32'(busy), 32'd0);
        check("t6_rst_mem",   32'({mem_addr, mem_data}), 32'd0);
        @(posedge clk_sys); #1;      // cycle 8: tie resolves to the CPU
        @(negedge clk_sys);
        check("t6_tie_grant", 32'(grant), 32'(2'b01));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
